mem_sequencer: RTL and testbench
================================

# mem_sequencer

Bus-side memory sequencer for the SLC-3 datapath, sitting directly downstream of the instruction sequencer/decoder. Converts the level-style `Mem_OE`/`Mem_WE` requests (held for three cycles per access) plus MAR/MDR into correctly ordered off-chip SRAM strobes. Returns read data on a registered `Data_to_CPU` bus in time for the decoder's second MDR load cycle. Optionally decodes the memory-mapped I/O word at x`FFFF`.

## Interface
- `WAIT_CYCLES`, default 1: cycles SRAM output enable is held before read data is captured; legal range 1..3. Only 1 meets the decoder's fixed 3-cycle read window.
- `Clk`  in  1  system clock. Reset `Reset`, synchronous, active-high; clock `Clk`.
- `Reset`  in  1  synchronous active-high reset.
- `Mem_OE`  in  1  read request level from the decoder.
- `Mem_WE`  in  1  write request level from the decoder.
- `MAR`  in  16  access address.
- `MDR`  in  16  write data.
- `Switches`  in  16  I/O read source (`MEM_IO_MAP_EN` only).
- `SRAM_DQ_IN`  in  16  SRAM data bus, read direction.
- `Data_to_CPU`  out  16  registered read data, feeds the MDR input mux.
- `Mem_Ready`  out  1  high while the access is complete and held.
- `SRAM_ADDR`  out  20  `{4'h0, latched MAR}`.
- `SRAM_CE_N`, `SRAM_OE_N`, `SRAM_WE_N`, `SRAM_UB_N`, `SRAM_LB_N`  out  1 each  active-low SRAM strobes.
- `SRAM_DQ_OUT`  out  16  latched MDR.
- `SRAM_DQ_OE`  out  1  tristate enable for `SRAM_DQ_OUT`.
- `HEX_Value`  out  16  I/O display register (`MEM_IO_MAP_EN` only).

## Operation
- States: IDLE, R_ACCESS, R_HOLD, W_SETUP, W_PULSE, W_HOLD.
- Leaving IDLE latches `MAR` into the address register and `MDR` into the write-data register. The latched values are used for the whole access.
- IDLE:
  - All strobes high, `SRAM_DQ_OE` = 0.
  - `Mem_WE` -> W_SETUP.
  - Else `Mem_OE` -> R_ACCESS.
  - Both high at once: write wins.
- R_ACCESS:
  - `CE_N` = `OE_N` = `UB_N` = `LB_N` = 0.
  - Cycle counter runs 0..`WAIT_CYCLES`-1. On the last count, capture `SRAM_DQ_IN` into `Data_to_CPU` and go to R_HOLD.
  - `Mem_OE` low before capture -> IDLE. No capture; `Data_to_CPU` keeps its old value.
- R_HOLD:
  - Strobes as in R_ACCESS, `Mem_Ready` = 1.
  - `Mem_OE` low -> IDLE.
- W_SETUP: `CE_N`/`UB_N`/`LB_N` = 0, `WE_N` = 1, `DQ_OE` = 1.
- W_PULSE: as W_SETUP but `WE_N` = 0.
- W_HOLD:
  - `WE_N` = 1, `CE_N` = 0, `DQ_OE` = 1, `Mem_Ready` = 1.
  - `Mem_WE` low -> IDLE.
- A started write always completes W_SETUP -> W_PULSE -> W_HOLD, even if `Mem_WE` drops early.
- `OE_N` and `WE_N` are never low in the same cycle.
- `DQ_OE` is high only in write states.
- All SRAM outputs and `Mem_Ready` are registered (state-decoded from registered state); no combinational path from `Mem_OE`/`Mem_WE` to any strobe.

## Timing
- Reset values:
  - State IDLE.
  - All `_N` strobes 1, `SRAM_DQ_OE` 0, `Mem_Ready` 0.
  - `Data_to_CPU`, `HEX_Value`, `SRAM_ADDR`, `SRAM_DQ_OUT` all 0.
- Reset mid-access: strobes deassert in the next cycle and the access is dropped. A write already in W_PULSE is truncated.
- Read, with `Mem_OE` rising in cycle 0:
  - R_ACCESS in cycle 1.
  - Capture at the end of cycle `WAIT_CYCLES`.
  - `Data_to_CPU` valid from cycle `WAIT_CYCLES`+1, i.e. cycle 2 by default, matching the decoder's third OE cycle.
- Write, with `Mem_WE` rising in cycle 0: W_SETUP in cycle 1, WE pulse in cycle 2, W_HOLD in cycle 3, IDLE in cycle 4 if `Mem_WE` has dropped.
- Back-to-back: a request seen in the cycle the FSM returns to IDLE is accepted immediately.

## Configuration
- `MEM_IO_MAP_EN` defined, and latched address = x`FFFF`:
  - Read: no SRAM strobes; `Switches` is captured into `Data_to_CPU` with the same timing as an SRAM read.
  - Write: no SRAM strobes; `HEX_Value` loads the latched MDR at the end of W_PULSE.
- `MEM_IO_MAP_EN` undefined:
  - x`FFFF` is ordinary SRAM.
  - `HEX_Value` is tied to 0 and `Switches` is ignored.

## Structure
- Package `slc3_mem_pkg` holds:
  - the state enum `mem_state_t`;
  - constant `IO_ADDR` = 16'hFFFF;
  - constant `SRAM_AW` = 20.
- One sub-module, `mem_io_map`: address-compare and `HEX_Value` register. It is instantiated only under `MEM_IO_MAP_EN`.

## Test plan
- Reset, then SRAM model holding x`1234` at x`0003`; `MAR` = x`0003`, `Mem_OE` high 3 cycles -> `OE_N` low cycles 1-3, `Data_to_CPU` = x`1234` from cycle 2, `Mem_Ready` high in cycle 3.
- `MAR` = x`0010`, `MDR` = x`BEEF`, `Mem_WE` high 3 cycles -> `WE_N` low only in cycle 2, `DQ_OE` high cycles 1-3; a subsequent read of x`0010` returns x`BEEF`.
- `Mem_OE` and `Mem_WE` rise together at `MAR` = x`0020` -> write sequence only, `OE_N` never low.
- `Mem_OE` pulsed for a single cycle with `WAIT_CYCLES` = 3 -> FSM returns to IDLE, `Data_to_CPU` unchanged.
- With `MEM_IO_MAP_EN`: write x`00A5` to x`FFFF` -> `HEX_Value` = x`00A5`, `CE_N` stays 1. Read x`FFFF` with `Switches` = x`0F0F` -> `Data_to_CPU` = x`0F0F`.
- `Reset` asserted in W_PULSE -> next cycle all strobes 1, `DQ_OE` 0, state IDLE.

Source files
------------

// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SLC-3 bus-side memory sequencer.
// Holds the sequencer state encoding, the memory-mapped I/O address and
// the SRAM address width, plus small state-classification helpers.
package slc3_mem_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        R_ACCESS = 3'd1,
        R_HOLD   = 3'd2,
        W_SETUP  = 3'd3,
        W_PULSE  = 3'd4,
        W_HOLD   = 3'd5
    } mem_state_t;

    localparam logic [15:0] IO_ADDR = 16'hFFFF;
    localparam int          SRAM_AW = 20;

    function automatic logic isReadState(mem_state_t s);
        return (s == R_ACCESS) || (s == R_HOLD);
    endfunction

    function automatic logic isWriteState(mem_state_t s);
        return (s == W_SETUP) || (s == W_PULSE) || (s == W_HOLD);
    endfunction

endpackage

// File: rtl/mem_io_map.sv
// Memory-mapped I/O word decoder for the SLC-3 sequencer.
// Compares the latched access address against the I/O word and owns the
// HEX display register, which loads the latched write data when the
// sequencer finishes its write pulse on the I/O address.
module mem_io_map
    import slc3_mem_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] addr_i,
    input  logic        hexLoad_i,
    input  logic [15:0] wrData_i,
    output logic        isIo_o,
    output logic [15:0] hexValue_o
);

    logic [15:0] hex_q;
    logic [15:0] hex_d;

    assign isIo_o     = (addr_i == IO_ADDR);
    assign hexValue_o = hex_q;

    // Load the display register only for a write pulse aimed at the I/O word.
    always_comb begin
        hex_d = hex_q;
        if (hexLoad_i && isIo_o) begin
            hex_d = wrData_i;
        end
    end

    // Display register, cleared by the synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            hex_q <= '0;
        end else begin
            hex_q <= hex_d;
        end
    end

endmodule

// File: rtl/mem_sequencer.sv
// Bus-side memory sequencer for the SLC-3 datapath.
// Turns the decoder's level-style Mem_OE / Mem_WE requests into ordered
// off-chip SRAM strobes, returns read data on a registered bus and keeps
// the write sequence setup -> pulse -> hold intact once started.
// Optional feature macro: MEM_IO_MAP_EN (decodes the I/O word at xFFFF to
// the Switches input and the HEX_Value display register).
// WAIT_CYCLES (1..3) sets how long output enable is held before capture;
// only 1 fits the decoder's fixed three-cycle read window.
module mem_sequencer
    import slc3_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
)
(
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Mem_OE,
    input  logic               Mem_WE,
    input  logic [15:0]        MAR,
    input  logic [15:0]        MDR,
    input  logic [15:0]        Switches,
    input  logic [15:0]        SRAM_DQ_IN,
    output logic [15:0]        Data_to_CPU,
    output logic               Mem_Ready,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_CE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_WE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N,
    output logic [15:0]        SRAM_DQ_OUT,
    output logic               SRAM_DQ_OE,
    output logic [15:0]        HEX_Value
);

    localparam logic [1:0] LAST_CNT = 2'(WAIT_CYCLES - 1);

    mem_state_t  state_q;
    mem_state_t  state_d;
    logic [15:0] addr_q;
    logic [15:0] addr_d;
    logic [15:0] wdata_q;
    logic [15:0] wdata_d;
    logic [15:0] rdata_q;
    logic [15:0] rdata_d;
    logic [1:0]  waitCnt_q;
    logic [1:0]  waitCnt_d;

    logic        isIo;
    logic [15:0] readSource;

`ifdef MEM_IO_MAP_EN
    logic hexLoad;

    assign hexLoad    = (state_q == W_PULSE);
    assign readSource = isIo ? Switches : SRAM_DQ_IN;

    mem_io_map u_io_map (
        .Clk        (Clk),
        .Reset      (Reset),
        .addr_i     (addr_q),
        .hexLoad_i  (hexLoad),
        .wrData_i   (wdata_q),
        .isIo_o     (isIo),
        .hexValue_o (HEX_Value)
    );
`else
    logic unusedSwitches;

    assign unusedSwitches = ^Switches;
    assign isIo           = 1'b0;
    assign readSource     = SRAM_DQ_IN;
    assign HEX_Value      = '0;
`endif

    // Next-state logic: accept requests from IDLE (write wins), pace the
    // read wait counter, and walk a started write through all three phases.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        waitCnt_d = waitCnt_q;

        case (state_q)
            IDLE: begin
                if (Mem_WE) begin
                    state_d = W_SETUP;
                    addr_d  = MAR;
                    wdata_d = MDR;
                end else if (Mem_OE) begin
                    state_d   = R_ACCESS;
                    addr_d    = MAR;
                    wdata_d   = MDR;
                    waitCnt_d = '0;
                end
            end

            R_ACCESS: begin
                if (!Mem_OE) begin
                    state_d = IDLE;
                end else if (waitCnt_q == LAST_CNT) begin
                    rdata_d = readSource;
                    state_d = R_HOLD;
                end else begin
                    waitCnt_d = waitCnt_q + 2'd1;
                end
            end

            R_HOLD: begin
                if (!Mem_OE) begin
                    state_d = IDLE;
                end
            end

            W_SETUP: begin
                state_d = W_PULSE;
            end

            W_PULSE: begin
                state_d = W_HOLD;
            end

            W_HOLD: begin
                if (!Mem_WE) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched address/data and captured read data; reset drops any access.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            waitCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            waitCnt_q <= waitCnt_d;
        end
    end

    // Strobe decode purely from registered state and address, so the request
    // inputs never reach the SRAM pins combinationally; the I/O word
    // suppresses every SRAM strobe.
    always_comb begin
        SRAM_CE_N  = 1'b1;
        SRAM_OE_N  = 1'b1;
        SRAM_WE_N  = 1'b1;
        SRAM_UB_N  = 1'b1;
        SRAM_LB_N  = 1'b1;
        SRAM_DQ_OE = 1'b0;
        Mem_Ready  = (state_q == R_HOLD) || (state_q == W_HOLD);

        if (!isIo) begin
            if (isReadState(state_q)) begin
                SRAM_CE_N = 1'b0;
                SRAM_OE_N = 1'b0;
                SRAM_UB_N = 1'b0;
                SRAM_LB_N = 1'b0;
            end
            if (isWriteState(state_q)) begin
                SRAM_CE_N  = 1'b0;
                SRAM_DQ_OE = 1'b1;
            end
            if ((state_q == W_SETUP) || (state_q == W_PULSE)) begin
                SRAM_UB_N = 1'b0;
                SRAM_LB_N = 1'b0;
            end
            if (state_q == W_PULSE) begin
                SRAM_WE_N = 1'b0;
            end
        end
    end

    assign Data_to_CPU = rdata_q;
    assign SRAM_ADDR   = {{(SRAM_AW - 16){1'b0}}, addr_q};
    assign SRAM_DQ_OUT = wdata_q;

endmodule

// File: tb/tb_mem_sequencer.sv
// Testbench for mem_sequencer: two instances (WAIT_CYCLES 1 and 3) share the
// request inputs, a small SRAM array answers the bus, and a cycle-count model
// of each access predicts every strobe and data output once per cycle.
module tb_mem_sequencer;

    typedef struct packed {
        logic [1:0]  kind;
        logic [2:0]  k;
        logic [15:0] addr;
        logic [15:0] wd;
        logic [15:0] data;
        logic [15:0] hex;
    } model_t;

    localparam logic [1:0] K_IDLE  = 2'd0;
    localparam logic [1:0] K_READ  = 2'd1;
    localparam logic [1:0] K_WRITE = 2'd2;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Mem_OE;
    logic        Mem_WE;
    logic [15:0] MAR;
    logic [15:0] MDR;
    logic [15:0] Switches;

    logic [15:0] dData, dDqOut, dHex, dDqIn;
    logic [19:0] dAddr;
    logic        dReady, dCeN, dOeN, dWeN, dUbN, dLbN, dDqOe;
    logic [15:0] tData, tDqOut, tHex, tDqIn;
    logic [19:0] tAddr;
    logic        tReady, tCeN, tOeN, tWeN, tUbN, tLbN, tDqOe;

    logic [15:0] sramMem [0:255];
    logic [15:0] modelMem [0:255];
    logic        memLoaded = 1'b0;
    logic        modelLoaded = 1'b0;
    model_t      m1 = '0;
    model_t      m3 = '0;
    logic        checkEn = 1'b0;

    int errors = 0;
    int checks = 0;
    int oeLowCount = 0;
    int weLowCount = 0;
    int ceLowCount = 0;
    int dqOeCount = 0;
    int readyCount = 0;

    always #5 Clk = ~Clk;

    mem_sequencer #(.WAIT_CYCLES(1)) dut (
        .Clk(Clk), .Reset(Reset), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
        .MAR(MAR), .MDR(MDR), .Switches(Switches), .SRAM_DQ_IN(dDqIn),
        .Data_to_CPU(dData), .Mem_Ready(dReady), .SRAM_ADDR(dAddr),
        .SRAM_CE_N(dCeN), .SRAM_OE_N(dOeN), .SRAM_WE_N(dWeN),
        .SRAM_UB_N(dUbN), .SRAM_LB_N(dLbN), .SRAM_DQ_OUT(dDqOut),
        .SRAM_DQ_OE(dDqOe), .HEX_Value(dHex)
    );

    mem_sequencer #(.WAIT_CYCLES(3)) dut3 (
        .Clk(Clk), .Reset(Reset), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
        .MAR(MAR), .MDR(MDR), .Switches(Switches), .SRAM_DQ_IN(tDqIn),
        .Data_to_CPU(tData), .Mem_Ready(tReady), .SRAM_ADDR(tAddr),
        .SRAM_CE_N(tCeN), .SRAM_OE_N(tOeN), .SRAM_WE_N(tWeN),
        .SRAM_UB_N(tUbN), .SRAM_LB_N(tLbN), .SRAM_DQ_OUT(tDqOut),
        .SRAM_DQ_OE(tDqOe), .HEX_Value(tHex)
    );

    assign dDqIn = sramMem[dAddr[7:0]];
    assign tDqIn = sramMem[tAddr[7:0]];

    function automatic logic [15:0] initWord(int i);
        if (i == 3) return 16'h1234;
        return (16'(i) * 16'h0101) ^ 16'h5A5A;
    endfunction

    function automatic logic isIoAddr(logic [15:0] a);
`ifdef MEM_IO_MAP_EN
        return a == 16'hFFFF;
`else
        return (a != a);
`endif
    endfunction

    // Bench SRAM: written by the WAIT_CYCLES=1 instance whenever its write pulse is on the pins.
    always @(posedge Clk) begin
        if (!memLoaded) begin
            for (int i = 0; i < 256; i++) sramMem[i] <= initWord(i);
            memLoaded <= 1'b1;
        end else if (!dCeN && !dWeN && dDqOe) begin
            sramMem[dAddr[7:0]] <= dDqOut;
        end
    end

    // One model step: what each access looks like, counted in cycles since it began.
    function automatic model_t stepModel(model_t m, int w, logic rst, logic oe, logic we,
                                         logic [15:0] mar, logic [15:0] mdr, logic [15:0] sw);
        model_t n = m;
        if (rst) return '0;
        case (m.kind)
            K_IDLE: begin
                if (we || oe) begin
                    n.kind = we ? K_WRITE : K_READ;
                    n.k    = 3'd1;
                    n.addr = mar;
                    n.wd   = mdr;
                end
            end
            K_READ: begin
                if (!oe) begin
                    n.kind = K_IDLE;
                end else if (int'(m.k) <= w) begin
                    if (int'(m.k) == w) n.data = isIoAddr(m.addr) ? sw : modelMem[m.addr[7:0]];
                    n.k = m.k + 3'd1;
                end
            end
            default: begin
                if (m.k == 3'd2 && isIoAddr(m.addr)) n.hex = m.wd;
                if (m.k < 3'd3) n.k = m.k + 3'd1;
                else if (!we) n.kind = K_IDLE;
            end
        endcase
        return n;
    endfunction

    // Model advance on every clock, with its own copy of memory contents.
    always @(posedge Clk) begin
        if (!modelLoaded) begin
            for (int i = 0; i < 256; i++) modelMem[i] <= initWord(i);
            modelLoaded <= 1'b1;
        end else if (m1.kind == K_WRITE && m1.k == 3'd2 && !isIoAddr(m1.addr)) begin
            modelMem[m1.addr[7:0]] <= m1.wd;
        end
        m1 <= stepModel(m1, 1, Reset, Mem_OE, Mem_WE, MAR, MDR, Switches);
        m3 <= stepModel(m3, 3, Reset, Mem_OE, Mem_WE, MAR, MDR, Switches);
    end

    task automatic checkVal(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(string tag, model_t m, int w,
                               logic ceN, logic oeN, logic weN, logic ubN, logic lbN,
                               logic dqOe, logic ready, logic [15:0] data,
                               logic [19:0] addr, logic [15:0] dqOut, logic [15:0] hex);
        logic eCe = 1'b1, eOe = 1'b1, eWe = 1'b1, eUbLb = 1'b1, eDq = 1'b0, eRdy = 1'b0;
        logic ubLbDefined = 1'b1;
        logic io = isIoAddr(m.addr);
        if (m.kind == K_READ) begin
            eRdy = (int'(m.k) > w);
            if (!io) begin eCe = 1'b0; eOe = 1'b0; eUbLb = 1'b0; end
        end else if (m.kind == K_WRITE) begin
            eRdy = (m.k >= 3'd3);
            if (!io) begin
                eCe = 1'b0;
                eDq = 1'b1;
                eWe = (m.k == 3'd2) ? 1'b0 : 1'b1;
                if (m.k < 3'd3) eUbLb = 1'b0;
                else ubLbDefined = 1'b0;
            end
        end
        checkVal({tag, " CE_N"}, 32'(ceN), 32'(eCe));
        checkVal({tag, " OE_N"}, 32'(oeN), 32'(eOe));
        checkVal({tag, " WE_N"}, 32'(weN), 32'(eWe));
        if (ubLbDefined) begin
            checkVal({tag, " UB_N"}, 32'(ubN), 32'(eUbLb));
            checkVal({tag, " LB_N"}, 32'(lbN), 32'(eUbLb));
        end
        checkVal({tag, " DQ_OE"}, 32'(dqOe), 32'(eDq));
        checkVal({tag, " Mem_Ready"}, 32'(ready), 32'(eRdy));
        checkVal({tag, " Data_to_CPU"}, 32'(data), 32'(m.data));
        checkVal({tag, " SRAM_ADDR"}, 32'(addr), 32'(m.addr));
        checkVal({tag, " SRAM_DQ_OUT"}, 32'(dqOut), 32'(m.wd));
        checkVal({tag, " HEX_Value"}, 32'(hex), 32'(m.hex));
    endtask

    // Per-cycle comparison a little after each rising edge, plus strobe tallies.
    always begin
        @(posedge Clk);
        #2;
        if (checkEn) begin
            checkOutput("w1", m1, 1, dCeN, dOeN, dWeN, dUbN, dLbN, dDqOe, dReady,
                        dData, dAddr, dDqOut, dHex);
            checkOutput("w3", m3, 3, tCeN, tOeN, tWeN, tUbN, tLbN, tDqOe, tReady,
                        tData, tAddr, tDqOut, tHex);
            if (!dOeN || !tOeN) oeLowCount++;
            if (!dWeN) weLowCount++;
            if (!dCeN || !tCeN) ceLowCount++;
            if (dDqOe) dqOeCount++;
            if (dReady) readyCount++;
        end
    end

    task automatic applyStimulus(logic oe, logic we, logic [15:0] mar, logic [15:0] mdr, int n);
        Mem_OE = oe;
        Mem_WE = we;
        MAR    = mar;
        MDR    = mdr;
        repeat (n) @(negedge Clk);
    endtask

    task automatic clearTallies();
        oeLowCount = 0;
        weLowCount = 0;
        ceLowCount = 0;
        dqOeCount  = 0;
        readyCount = 0;
    endtask

    initial begin
        Reset = 1'b1;
        Mem_OE = 1'b0;
        Mem_WE = 1'b0;
        MAR = '0;
        MDR = '0;
        Switches = 16'h0F0F;
        repeat (2) @(negedge Clk);

        checkVal("reset strobes", 32'({dCeN, dOeN, dWeN, dUbN, dLbN}), 32'h1F);
        checkVal("reset DQ_OE/Ready", 32'({dDqOe, dReady}), 32'h0);
        checkVal("reset Data_to_CPU", 32'(dData), 32'h0);
        checkVal("reset SRAM_ADDR", 32'(dAddr), 32'h0);
        checkVal("reset DQ_OUT/HEX", 32'({dDqOut, dHex}), 32'h0);
        checkEn = 1'b1;
        Reset = 1'b0;

        $display("[TB] read x0003");
        clearTallies();
        applyStimulus(1'b1, 1'b0, 16'h0003, 16'h0000, 3);
        applyStimulus(1'b0, 1'b0, 16'h0003, 16'h0000, 2);
        checkVal("read data", 32'(dData), 32'h1234);
        checkVal("read OE_N low cycles", 32'(oeLowCount), 32'd3);
        checkVal("read Ready cycles", 32'(readyCount), 32'd2);
        checkVal("w3 short window no capture", 32'(tData), 32'h0);

        $display("[TB] write xBEEF to x0010, read back");
        clearTallies();
        applyStimulus(1'b0, 1'b1, 16'h0010, 16'hBEEF, 3);
        applyStimulus(1'b0, 1'b0, 16'h0010, 16'h0000, 2);
        checkVal("write WE_N low cycles", 32'(weLowCount), 32'd1);
        checkVal("write DQ_OE cycles", 32'(dqOeCount), 32'd3);
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000, 3);
        applyStimulus(1'b0, 1'b0, 16'h0010, 16'h0000, 2);
        checkVal("readback data", 32'(dData), 32'hBEEF);

        $display("[TB] OE and WE together at x0020");
        clearTallies();
        applyStimulus(1'b1, 1'b1, 16'h0020, 16'h5555, 3);
        applyStimulus(1'b0, 1'b0, 16'h0020, 16'h0000, 2);
        checkVal("both OE_N low cycles", 32'(oeLowCount), 32'd0);
        checkVal("both WE_N low cycles", 32'(weLowCount), 32'd1);

        $display("[TB] long read then single-cycle OE pulse");
        applyStimulus(1'b1, 1'b0, 16'h0003, 16'h0000, 5);
        applyStimulus(1'b0, 1'b0, 16'h0003, 16'h0000, 2);
        checkVal("w3 long read data", 32'(tData), 32'h1234);
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000, 1);
        applyStimulus(1'b0, 1'b0, 16'h0010, 16'h0000, 3);
        checkVal("w3 pulse keeps data", 32'(tData), 32'h1234);
        checkVal("w1 pulse keeps data", 32'(dData), 32'h1234);

        $display("[TB] back-to-back write then read x0040");
        applyStimulus(1'b0, 1'b1, 16'h0040, 16'hCAFE, 3);
        applyStimulus(1'b1, 1'b0, 16'h0040, 16'h0000, 4);
        applyStimulus(1'b0, 1'b0, 16'h0040, 16'h0000, 2);
        checkVal("back-to-back data", 32'(dData), 32'hCAFE);

        $display("[TB] reset during write pulse");
        applyStimulus(1'b0, 1'b1, 16'h0030, 16'h1111, 2);
        checkVal("pulse WE_N", 32'(dWeN), 32'h0);
        Reset = 1'b1;
        @(negedge Clk);
        checkVal("reset-in-pulse strobes", 32'({dCeN, dOeN, dWeN, dUbN, dLbN}), 32'h1F);
        checkVal("reset-in-pulse DQ_OE/Ready", 32'({dDqOe, dReady}), 32'h0);
        checkVal("reset-in-pulse data", 32'(dData), 32'h0);
        Reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 2);

        $display("[TB] I/O word xFFFF");
        clearTallies();
        applyStimulus(1'b0, 1'b1, 16'hFFFF, 16'h00A5, 3);
        applyStimulus(1'b0, 1'b0, 16'hFFFF, 16'h0000, 2);
        applyStimulus(1'b1, 1'b0, 16'hFFFF, 16'h0000, 3);
        applyStimulus(1'b0, 1'b0, 16'hFFFF, 16'h0000, 2);
`ifdef MEM_IO_MAP_EN
        checkVal("io HEX_Value", 32'(dHex), 32'h00A5);
        checkVal("io read data", 32'(dData), 32'h0F0F);
        checkVal("io CE_N low cycles", 32'(ceLowCount), 32'd0);
`else
        checkVal("plain xFFFF HEX_Value", 32'(dHex), 32'h0);
        checkVal("plain xFFFF read data", 32'(dData), 32'h00A5);
        checkVal("plain xFFFF WE_N low cycles", 32'(weLowCount), 32'd1);
`endif

        checkEn = 1'b0;
        @(negedge Clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
